// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, PC state encoding and the
// opcodes the control unit decodes into the PC controls.
package cpu_pkg;

  localparam int ADDR_W_DEFAULT = 10;
  localparam int DATA_W_DEFAULT = 32;

  // PC state encoding kept as plain constants so legacy blocks can compare bits.
  typedef logic [1:0] pc_state_t;
  localparam pc_state_t S_RUN     = 2'd0;
  localparam pc_state_t S_WAIT_IN = 2'd1;
  localparam pc_state_t S_HALT    = 2'd2;

  localparam logic [5:0] OP_HALT  = 6'b011001;
  localparam logic [5:0] OP_IN    = 6'b010110;
  localparam logic [5:0] OP_JUMPI = 6'b010000;
  localparam logic [5:0] OP_JMP   = 6'b010001;

endpackage

// File: rtl/rise_detect.sv
// Registers a level input and flags the cycle where it goes from 0 to 1.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/pc_unit.sv
// Program counter for the single-cycle core: run / wait-for-input / halt
// control, jump target selection, resume-after-HALT and a retired-instruction counter.
module pc_unit #(
  parameter int ADDR_W = cpu_pkg::ADDR_W_DEFAULT,
  parameter int DATA_W = cpu_pkg::DATA_W_DEFAULT,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ResetPC,
  input  logic              HaltPC,
  input  logic              jump_stop,
  input  logic              mux4,
  input  logic              mux5,
  input  logic [ADDR_W-1:0] imm_target,
  input  logic [DATA_W-1:0] reg_target,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              waiting_in,
  output logic              pc_overflow,
  output logic [CNT_W-1:0]  instr_count
);

  import cpu_pkg::*;

  pc_state_t         state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic              retire;
  logic              ovf_set;
  logic              resume_rise;

  // Jump addresses wider than the instruction space are truncated on purpose.
  logic unused_reg_hi;
  assign unused_reg_hi = ^reg_target[DATA_W-1:ADDR_W];

  rise_detect u_resume_edge (
    .clk   (clk),
    .reset (reset),
    .d     (resume),
    .rise  (resume_rise)
  );

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_n    = pc;
    state_n = state;
    retire  = 1'b0;
    ovf_set = 1'b0;
    if (state == S_HALT) begin
      if (ResetPC) begin
        pc_n    = '0;
        state_n = S_RUN;
      end else if (resume_rise) begin
        // Step over the HALT word without counting it as retired.
        pc_n    = pc + ADDR_W'(1);
        state_n = S_RUN;
      end
    end else begin
      if (ResetPC) begin
        pc_n    = '0;
        state_n = S_RUN;
      end else if (HaltPC) begin
        state_n = S_HALT;
      end else if (jump_stop) begin
        state_n = S_WAIT_IN;
      end else if (mux5) begin
        pc_n    = mux4 ? imm_target : reg_target[ADDR_W-1:0];
        retire  = 1'b1;
        state_n = S_RUN;
      end else begin
        pc_n    = pc + ADDR_W'(1);
        ovf_set = &pc;
        retire  = 1'b1;
        state_n = S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      state       <= S_RUN;
      pc_overflow <= 1'b0;
      instr_count <= '0;
    end else begin
      pc    <= pc_n;
      state <= state_n;
      if (ovf_set) pc_overflow <= 1'b1;
      if (retire && !(&instr_count)) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign halted     = (state == S_HALT);
  assign waiting_in = (state == S_WAIT_IN);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random
// control traffic, all compared against a behavioural PC model.
module tb_pc_unit;

  import cpu_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;
  localparam int PC_MOD = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset, ResetPC, HaltPC, jump_stop, mux4, mux5, resume;
  logic [ADDR_W-1:0] imm_target;
  logic [DATA_W-1:0] reg_target;
  logic [ADDR_W-1:0] pc;
  logic              halted, waiting_in, pc_overflow;
  logic [CNT_W-1:0]  instr_count;

  int checks   = 0;
  int failures = 0;

  // Behavioural reference state
  int unsigned m_pc;
  bit          m_halted, m_waiting, m_ovf, m_resume_prev;
  longint      m_cnt;

  pc_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .ResetPC     (ResetPC),
    .HaltPC      (HaltPC),
    .jump_stop   (jump_stop),
    .mux4        (mux4),
    .mux5        (mux5),
    .imm_target  (imm_target),
    .reg_target  (reg_target),
    .resume      (resume),
    .pc          (pc),
    .halted      (halted),
    .waiting_in  (waiting_in),
    .pc_overflow (pc_overflow),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    if (reset) begin
      m_pc = 0; m_halted = 0; m_waiting = 0; m_ovf = 0; m_cnt = 0; m_resume_prev = 0;
      return;
    end
    if (m_halted) begin
      if (ResetPC) begin
        m_pc = 0; m_halted = 0;
      end else if (resume && !m_resume_prev) begin
        m_pc = (m_pc + 1) % PC_MOD; m_halted = 0;
      end
    end else if (ResetPC) begin
      m_pc = 0; m_waiting = 0;
    end else if (HaltPC) begin
      m_halted = 1; m_waiting = 0;
    end else if (jump_stop) begin
      m_waiting = 1;
    end else begin
      m_waiting = 0;
      if (mux5) m_pc = mux4 ? int'(imm_target) : int'(reg_target % PC_MOD);
      else begin
        if (m_pc == PC_MOD - 1) m_ovf = 1;
        m_pc = (m_pc + 1) % PC_MOD;
      end
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end
    m_resume_prev = resume;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},          64'(pc),          64'(m_pc));
    check({tag, ".halted"},      64'(halted),      64'(m_halted));
    check({tag, ".waiting_in"},  64'(waiting_in),  64'(m_waiting));
    check({tag, ".pc_overflow"}, 64'(pc_overflow), 64'(m_ovf));
    check({tag, ".instr_count"}, 64'(instr_count), 64'(m_cnt));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    ResetPC = 0; HaltPC = 0; jump_stop = 0; mux5 = 0; mux4 = 0;
  endtask

  // Control-unit view: turn an opcode into the PC control lines.
  task automatic issue(input logic [5:0] op);
    idle();
    HaltPC    = (op == OP_HALT);
    jump_stop = (op == OP_IN);
    mux5      = (op == OP_JUMPI) || (op == OP_JMP);
    mux4      = (op == OP_JUMPI);
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick("reset");
    reset = 0;
  endtask

  initial begin
    reset = 1; resume = 0; imm_target = '0; reg_target = '0;
    idle();
    m_pc = 0; m_halted = 0; m_waiting = 0; m_ovf = 0; m_cnt = 0; m_resume_prev = 0;
    @(negedge clk);

    // Reset state
    tick("reset0");
    check("reset_pc", 64'(pc), 64'd0);
    check("reset_cnt", 64'(instr_count), 64'd0);
    reset = 0;

    // Five sequential instructions
    for (int i = 0; i < 5; i++) tick("idle");
    check("idle_pc", 64'(pc), 64'd5);
    check("idle_cnt", 64'(instr_count), 64'd5);
    check("idle_halted", 64'(halted), 64'd0);

    // Immediate and register jump sources
    do_reset();
    for (int i = 0; i < 3; i++) tick("to3");
    issue(OP_JUMPI); imm_target = 10'h02A;
    tick("jumpi");
    check("jumpi_pc", 64'(pc), 64'h02A);
    issue(OP_JMP); reg_target = 32'h0000_0413;
    tick("jmp");
    check("jmp_pc", 64'(pc), 64'h013);
    idle();

    // Halt at pc=7, stay halted without resume, then a resume edge
    do_reset();
    for (int i = 0; i < 7; i++) tick("to7");
    issue(OP_HALT);
    tick("halt");
    idle();
    for (int i = 0; i < 10; i++) tick("halted");
    check("halt_pc", 64'(pc), 64'd7);
    check("halt_flag", 64'(halted), 64'd1);
    resume = 1;
    tick("resume");
    check("resume_pc", 64'(pc), 64'd8);
    check("resume_cnt", 64'(instr_count), 64'd7);
    check("resume_halted", 64'(halted), 64'd0);

    // Resume already high on halt entry needs a fresh rising edge
    issue(OP_HALT);
    tick("halt_hi");
    idle();
    for (int i = 0; i < 4; i++) tick("held_hi");
    check("held_hi_halted", 64'(halted), 64'd1);
    resume = 0;
    tick("resume_low");
    resume = 1;
    tick("resume_rise");
    check("rerise_pc", 64'(pc), 64'd9);
    check("rerise_halted", 64'(halted), 64'd0);
    resume = 0;

    // Input stall at pc=4
    do_reset();
    for (int i = 0; i < 4; i++) tick("to4");
    issue(OP_IN);
    for (int i = 0; i < 3; i++) tick("stall");
    check("stall_pc", 64'(pc), 64'd4);
    check("stall_wait", 64'(waiting_in), 64'd1);
    idle();
    tick("unstall");
    check("unstall_pc", 64'(pc), 64'd5);
    check("unstall_cnt", 64'(instr_count), 64'd5);

    // Halt wins over a simultaneous jump; ResetPC releases a halt
    HaltPC = 1; mux5 = 1; mux4 = 1; imm_target = 10'h155;
    tick("halt_vs_jump");
    check("halt_vs_jump_pc", 64'(pc), 64'd5);
    idle(); ResetPC = 1;
    tick("resetpc_halt");
    check("resetpc_halt_pc", 64'(pc), 64'd0);
    check("resetpc_halt_flag", 64'(halted), 64'd0);
    idle();

    // Wrap from 0x3FF sets a sticky overflow that only reset clears
    issue(OP_JUMPI); imm_target = 10'h3FF;
    tick("to_max");
    idle();
    tick("wrap");
    check("wrap_pc", 64'(pc), 64'd0);
    check("wrap_ovf", 64'(pc_overflow), 64'd1);
    issue(OP_JUMPI); imm_target = 10'h100;
    tick("post_wrap_jump");
    idle(); ResetPC = 1;
    tick("post_wrap_resetpc");
    check("ovf_sticky", 64'(pc_overflow), 64'd1);
    do_reset();
    check("ovf_cleared", 64'(pc_overflow), 64'd0);

    // Random control traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(99) == 0);
      ResetPC    = ($urandom_range(39) == 0);
      HaltPC     = ($urandom_range(14) == 0);
      jump_stop  = ($urandom_range(4) == 0);
      mux5       = ($urandom_range(3) == 0);
      mux4       = 1'($urandom_range(1));
      imm_target = ($urandom_range(7) == 0) ? 10'h3FF : 10'($urandom);
      reg_target = $urandom;
      if ($urandom_range(3) == 0) resume = ~resume;
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
